// File: rtl/seed_extender.sv
// Ungapped X-drop seed extension: grows a seed hit right then left, one nucleotide
// per cycle, and reports the best-scoring HSP with a one-cycle stop/result pulse.
module seed_extender #(
    parameter int SEED_LEN  = 11,
    parameter int MATCH     = 1,
    parameter int MISMATCH  = 3,
    parameter int XDROP     = 10,
    parameter int THRESHOLD = 20,
    parameter int SCORE_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_expand,
    input  logic [8:0]                loc_q,
    input  logic [8:0]                shift_no,
    input  logic [511:0]              query,
    input  logic [511:0]              db,
    output logic                      stop,
    output logic                      result_valid,
    output logic                      hsp_pass,
    output logic signed [SCORE_W-1:0] hsp_score,
    output logic [7:0]                hsp_q_start,
    output logic [7:0]                hsp_q_end,
    output logic [7:0]                hsp_db_start,
    output logic                      busy
);

    typedef enum logic [2:0] {IDLE, EXT_RIGHT, EXT_LEFT, REPORT, WAIT_RELEASE} state_t;

    localparam logic signed [SCORE_W-1:0] SEED_SCORE = SCORE_W'(SEED_LEN * MATCH);
    localparam logic signed [SCORE_W-1:0] MATCH_S    = SCORE_W'(MATCH);
    localparam logic signed [SCORE_W-1:0] MISMATCH_S = SCORE_W'(MISMATCH);
    localparam logic signed [SCORE_W-1:0] XDROP_S    = SCORE_W'(XDROP);
    localparam logic signed [SCORE_W-1:0] THRESH_S   = SCORE_W'(THRESHOLD);

    state_t state, stateNext;

    logic [511:0] qWin, dbWin;
    logic [7:0]   qs, ds, qStart, qEnd, dbStart;
    logic [8:0]   n;
    logic signed [SCORE_W-1:0] score, best;

    logic [9:0] qi, di;
    logic [1:0] qNuc, dNuc;
    logic       outRange, lastIdx, improve, xdrop, dirDone;
    logic signed [SCORE_W-1:0] newScore, newBest, curBest;
    logic [7:0] curQStart, curDbStart;

    // Only even bit offsets are meaningful; bit0 is don't-care.
    logic unusedBits;
    assign unusedBits = loc_q[0] ^ shift_no[0];

    always_comb begin
        if (state == EXT_LEFT) begin
            qi = {2'b00, qs} - 10'd1 - {1'b0, n};
            di = {2'b00, ds} - 10'd1 - {1'b0, n};
        end else begin
            qi = {2'b00, qs} + 10'(SEED_LEN) + {1'b0, n};
            di = {2'b00, ds} + 10'(SEED_LEN) + {1'b0, n};
        end
        // Left-side underflow wraps above 255 in 10 bits, so one range test covers both sides.
        outRange = (qi > 10'd255) || (di > 10'd255);
        qNuc     = qWin[{qi[7:0], 1'b0} +: 2];
        dNuc     = dbWin[{di[7:0], 1'b0} +: 2];
        newScore = (qNuc == dNuc) ? score + MATCH_S : score - MISMATCH_S;
        improve  = newScore > best;
        newBest  = improve ? newScore : best;
        xdrop    = (newBest - newScore) > XDROP_S;
        lastIdx  = (state == EXT_LEFT) ? (qi == 10'd0 || di == 10'd0)
                                       : (qi == 10'd255 || di == 10'd255);
        dirDone  = outRange || xdrop || lastIdx;

        curBest    = outRange ? best : newBest;
        curQStart  = (!outRange && improve) ? qi[7:0] : qStart;
        curDbStart = (!outRange && improve) ? di[7:0] : dbStart;

        stateNext = state;
        case (state)
            IDLE:         if (start_expand) stateNext = EXT_RIGHT;
            EXT_RIGHT:    if (dirDone) stateNext = EXT_LEFT;
            EXT_LEFT:     if (dirDone) stateNext = REPORT;
            REPORT:       stateNext = WAIT_RELEASE;
            WAIT_RELEASE: if (!start_expand) stateNext = IDLE;
            default:      stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            qWin         <= '0;
            dbWin        <= '0;
            qs           <= '0;
            ds           <= '0;
            qStart       <= '0;
            qEnd         <= '0;
            dbStart      <= '0;
            n            <= '0;
            score        <= '0;
            best         <= '0;
            hsp_score    <= '0;
            hsp_pass     <= 1'b0;
            hsp_q_start  <= '0;
            hsp_q_end    <= '0;
            hsp_db_start <= '0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: if (start_expand) begin
                    qWin    <= query;
                    dbWin   <= db;
                    qs      <= loc_q[8:1];
                    ds      <= shift_no[8:1];
                    qStart  <= loc_q[8:1];
                    qEnd    <= loc_q[8:1] + 8'(SEED_LEN - 1);
                    dbStart <= shift_no[8:1];
                    score   <= SEED_SCORE;
                    best    <= SEED_SCORE;
                    n       <= '0;
                end
                EXT_RIGHT: begin
                    n <= n + 9'd1;
                    if (!outRange) begin
                        score <= newScore;
                        best  <= newBest;
                        if (improve) qEnd <= qi[7:0];
                    end
                    // Left extension restarts from the best right-side score.
                    if (dirDone) begin
                        n     <= '0;
                        score <= curBest;
                    end
                end
                EXT_LEFT: begin
                    n <= n + 9'd1;
                    if (!outRange) begin
                        score <= newScore;
                        best  <= newBest;
                        if (improve) begin
                            qStart  <= qi[7:0];
                            dbStart <= di[7:0];
                        end
                    end
                    if (dirDone) begin
                        hsp_score    <= curBest;
                        hsp_pass     <= curBest >= THRESH_S;
                        hsp_q_start  <= curQStart;
                        hsp_q_end    <= qEnd;
                        hsp_db_start <= curDbStart;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stop         = (state == REPORT);
    assign result_valid = (state == REPORT);
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_seed_extender.sv
// Directed and randomized checks of seed_extender against a loop-based
// reference model of X-drop extension over nucleotide arrays.
module tb_seed_extender;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_expand;
    logic [8:0]         loc_q, shift_no;
    logic [511:0]       query, db;
    logic               stop, result_valid, hsp_pass, busy;
    logic signed [15:0] hsp_score;
    logic [7:0]         hsp_q_start, hsp_q_end, hsp_db_start;

    int nComp = 0;
    int nErr  = 0;

    bit [1:0] qN[256];
    bit [1:0] dN[256];
    int eScore, eQS, eQE, eDS, eCyc;

    seed_extender dut (
        .clk(clk), .rst(rst), .start_expand(start_expand),
        .loc_q(loc_q), .shift_no(shift_no), .query(query), .db(db),
        .stop(stop), .result_valid(result_valid), .hsp_pass(hsp_pass),
        .hsp_score(hsp_score), .hsp_q_start(hsp_q_start), .hsp_q_end(hsp_q_end),
        .hsp_db_start(hsp_db_start), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nComp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk outward from the seed on plain arrays.
    task automatic model(input int qs, input int ds);
        int score, best, qi, di, cR, cL;
        score = 11; best = 11;
        eQS = qs; eQE = qs + 10; eDS = ds;
        qi = qs + 11; di = ds + 11; cR = 0;
        if (qi > 255 || di > 255) cR = 1;
        else while (1) begin
            cR++;
            score += (qN[qi] == dN[di]) ? 1 : -3;
            if (score > best) begin best = score; eQE = qi; end
            if (best - score > 10 || qi == 255 || di == 255) break;
            qi++; di++;
        end
        score = best;
        qi = qs - 1; di = ds - 1; cL = 0;
        if (qi < 0 || di < 0) cL = 1;
        else while (1) begin
            cL++;
            score += (qN[qi] == dN[di]) ? 1 : -3;
            if (score > best) begin best = score; eQS = qi; eDS = di; end
            if (best - score > 10 || qi == 0 || di == 0) break;
            qi--; di--;
        end
        eScore = best;
        eCyc   = 1 + cR + cL;
    endtask

    task automatic runCase(input string tag, input int qs, input int ds);
        logic [511:0] qv, dv;
        int cyc, extra;
        bit got;
        for (int i = 0; i < 256; i++) begin
            qv[2*i +: 2] = qN[i];
            dv[2*i +: 2] = dN[i];
        end
        model(qs, ds);
        query = qv; db = dv;
        loc_q        = {qs[7:0], 1'($urandom)};
        shift_no     = {ds[7:0], 1'($urandom)};
        start_expand = 1'b1;
        cyc = 0; got = 0;
        while (!got && cyc < 700) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                query = {16{$urandom}};
                db    = {16{$urandom}};
            end
            if (stop) got = 1;
        end
        check({tag, ".stop"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, ".latency"}, 32'(cyc), 32'(eCyc));
            check({tag, ".valid"},   32'(result_valid), 32'd1);
            check({tag, ".score"},   32'(hsp_score), 32'(eScore));
            check({tag, ".pass"},    32'(hsp_pass), 32'(eScore >= 20));
            check({tag, ".qstart"},  32'(hsp_q_start), 32'(eQS));
            check({tag, ".qend"},    32'(hsp_q_end), 32'(eQE));
            check({tag, ".dbstart"}, 32'(hsp_db_start), 32'(eDS));
        end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (stop) extra++;
        end
        check({tag, ".nodouble"}, 32'(extra), 32'd0);
        check({tag, ".waitbusy"}, 32'(busy), 32'd1);
        start_expand = 1'b0;
        tick();
        check({tag, ".idle"}, 32'(busy), 32'd0);
        check({tag, ".hold"}, 32'(hsp_score), 32'(eScore));
    endtask

    initial begin
        rst = 1'b1; start_expand = 1'b1; loc_q = '0; shift_no = '0;
        query = '0; db = '0;
        repeat (3) tick();
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.stop", 32'(stop), 32'd0);
        check("rst.valid", 32'(result_valid), 32'd0);
        check("rst.score", 32'(hsp_score), 32'd0);
        check("rst.qend", 32'(hsp_q_end), 32'd0);
        start_expand = 1'b0; rst = 1'b0;
        tick();

        // Identical windows, seed at 0: full-length right, empty left.
        for (int i = 0; i < 256; i++) begin qN[i] = 2'($urandom); dN[i] = qN[i]; end
        runCase("full", 0, 0);

        // Only the seed matches.
        for (int i = 0; i < 256; i++) begin qN[i] = 2'd0; dN[i] = 2'd1; end
        for (int i = 100; i <= 110; i++) begin qN[i] = 2'd2; dN[i] = 2'd2; end
        runCase("isolated", 100, 100);

        // DB-limited right extension, aligned with offset 90.
        for (int i = 0; i < 256; i++) begin qN[i] = 2'($urandom); dN[i] = 2'($urandom); end
        for (int j = 90; j < 256; j++) dN[j] = qN[j-90];
        runCase("shifted", 10, 100);

        // 3 match, 1 mismatch, 1 match, then mismatches.
        for (int i = 0; i < 256; i++) begin qN[i] = 2'd0; dN[i] = 2'd1; end
        for (int i = 200; i <= 213; i++) dN[i] = 2'd0;
        dN[215] = 2'd0;
        runCase("xdrop", 200, 200);

        // Seed ends at the window edge: empty right cycle.
        for (int i = 0; i < 256; i++) begin qN[i] = 2'($urandom); dN[i] = 2'($urandom); end
        runCase("edge", 245, 0);

        for (int k = 0; k < 20; k++) begin
            int qs, ds, src;
            qs = $urandom_range(0, 245);
            ds = $urandom_range(0, 245);
            for (int i = 0; i < 256; i++) begin qN[i] = 2'($urandom); dN[i] = 2'($urandom); end
            if (k % 4 != 0)
                for (int j = 0; j < 256; j++) begin
                    src = j - ds + qs;
                    if (src >= 0 && src < 256 && $urandom_range(0, 9) != 0) dN[j] = qN[src];
                end
            runCase($sformatf("rand%0d", k), qs, ds);
        end

        // Abort mid right extension.
        for (int i = 0; i < 256; i++) begin qN[i] = 2'($urandom); dN[i] = qN[i]; end
        for (int i = 0; i < 256; i++) begin query[2*i +: 2] = qN[i]; db[2*i +: 2] = dN[i]; end
        loc_q = '0; shift_no = '0; start_expand = 1'b1;
        repeat (50) tick();
        check("abort.busy_before", 32'(busy), 32'd1);
        rst = 1'b1; start_expand = 1'b0;
        tick();
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.stop", 32'(stop), 32'd0);
        check("abort.score", 32'(hsp_score), 32'd0);
        check("abort.qstart", 32'(hsp_q_start), 32'd0);
        check("abort.pass", 32'(hsp_pass), 32'd0);
        rst = 1'b0;
        repeat (3) begin
            tick();
            check("abort.nostop", 32'(stop), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nErr);
        $finish;
    end

endmodule
